// File: rtl/rasterizador_triangulo.sv
// Triangle rasterizer: bounding-box scan, one candidate per cycle, ready/valid point stream.
// Optional ORIENTACAO_DUPLA_EN also accepts clockwise triangles (all edge values <= 0).
module rasterizador_triangulo (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [11:0] Ponto1X,
    input  logic [11:0] Ponto1Y,
    input  logic [11:0] Ponto2X,
    input  logic [11:0] Ponto2Y,
    input  logic [11:0] Ponto3X,
    input  logic [11:0] Ponto3Y,
    input  logic        out_ready,
    output logic        busy,
    output logic        out_valid,
    output logic [11:0] out_x,
    output logic [11:0] out_y,
    output logic        done,
    output logic [24:0] num_pontos
);
    // state | meaning
    // IDLE  | waiting for start
    // SETUP | bounding box and cursor init
    // SCAN  | one cursor point per cycle, stalls on back-pressure
    // DONE  | one-cycle done pulse
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SETUP = 2'd1;
    localparam logic [1:0] SCAN  = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    logic [1:0]  estado;
    logic [11:0] v1x, v1y, v2x, v2y, v3x, v3y;
    logic [11:0] xmin, xmax, ymax;
    logic [11:0] cx, cy;
    logic        ultimo;
    logic [11:0] bb_xmin, bb_xmax, bb_ymin, bb_ymax;
    logic signed [26:0] e1, e2, e3;
    logic        dentro, fim_cursor, parado;

    function automatic logic signed [26:0] edge_val(
        input logic [11:0] ax, input logic [11:0] ay,
        input logic [11:0] bx, input logic [11:0] by,
        input logic [11:0] px, input logic [11:0] py);
        logic signed [12:0] dpx, day, dax, dpy;
        logic signed [25:0] p1, p2;
        dpx = $signed({1'b0, px}) - $signed({1'b0, bx});
        day = $signed({1'b0, ay}) - $signed({1'b0, by});
        dax = $signed({1'b0, ax}) - $signed({1'b0, bx});
        dpy = $signed({1'b0, py}) - $signed({1'b0, by});
        p1 = dpx * day;
        p2 = dax * dpy;
        edge_val = 27'(p1) - 27'(p2);
    endfunction

    function automatic logic [11:0] min3(input logic [11:0] a, input logic [11:0] b,
                                         input logic [11:0] c);
        logic [11:0] m;
        m = (a < b) ? a : b;
        min3 = (m < c) ? m : c;
    endfunction

    function automatic logic [11:0] max3(input logic [11:0] a, input logic [11:0] b,
                                         input logic [11:0] c);
        logic [11:0] m;
        m = (a > b) ? a : b;
        max3 = (m > c) ? m : c;
    endfunction

    always_comb begin
        bb_xmin = min3(v1x, v2x, v3x);
        bb_xmax = max3(v1x, v2x, v3x);
        bb_ymin = min3(v1y, v2y, v3y);
        bb_ymax = max3(v1y, v2y, v3y);
    end

    always_comb begin
        e1 = edge_val(v1x, v1y, v2x, v2y, cx, cy);
        e2 = edge_val(v2x, v2y, v3x, v3y, cx, cy);
        e3 = edge_val(v3x, v3y, v1x, v1y, cx, cy);
`ifdef ORIENTACAO_DUPLA_EN
        dentro = (!e1[26] && !e2[26] && !e3[26]) ||
                 ((e1[26] || e1 == 27'sd0) && (e2[26] || e2 == 27'sd0) &&
                  (e3[26] || e3 == 27'sd0));
`else
        dentro = !e1[26] && !e2[26] && !e3[26];
`endif
        fim_cursor = (cx == xmax) && (cy == ymax);
        parado     = out_valid && !out_ready;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado     <= IDLE;
            busy       <= 1'b0;
            out_valid  <= 1'b0;
            out_x      <= '0;
            out_y      <= '0;
            done       <= 1'b0;
            num_pontos <= '0;
            v1x <= '0; v1y <= '0; v2x <= '0; v2y <= '0; v3x <= '0; v3y <= '0;
            xmin <= '0; xmax <= '0; ymax <= '0;
            cx <= '0; cy <= '0;
            ultimo <= 1'b0;
        end else begin
            done <= 1'b0;
            case (estado)
                IDLE: begin
                    if (start) begin
                        v1x <= Ponto1X; v1y <= Ponto1Y;
                        v2x <= Ponto2X; v2y <= Ponto2Y;
                        v3x <= Ponto3X; v3y <= Ponto3Y;
                        busy       <= 1'b1;
                        num_pontos <= '0;
                        out_valid  <= 1'b0;
                        estado     <= SETUP;
                    end
                end
                SETUP: begin
                    xmin   <= bb_xmin;
                    xmax   <= bb_xmax;
                    ymax   <= bb_ymax;
                    cx     <= bb_xmin;
                    cy     <= bb_ymin;
                    ultimo <= 1'b0;
                    estado <= SCAN;
                end
                SCAN: begin
                    if (!parado) begin
                        if (out_valid) num_pontos <= num_pontos + 25'd1;
                        // ultimo: the final cursor was emitted and is being handed off now
                        if (ultimo) begin
                            out_valid <= 1'b0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            estado    <= DONE;
                        end else begin
                            out_valid <= dentro;
                            if (dentro) begin
                                out_x <= cx;
                                out_y <= cy;
                            end
                            if (fim_cursor) begin
                                if (dentro) begin
                                    ultimo <= 1'b1;
                                end else begin
                                    busy   <= 1'b0;
                                    done   <= 1'b1;
                                    estado <= DONE;
                                end
                            end else if (cx == xmax) begin
                                cx <= xmin;
                                cy <= cy + 12'd1;
                            end else begin
                                cx <= cx + 12'd1;
                            end
                        end
                    end
                end
                default: begin
                    estado <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_rasterizador_triangulo.sv
// Self-checking bench for rasterizador_triangulo: reference point list from the edge
// inequalities, compared against the output stream under random back-pressure.
module tb_rasterizador_triangulo;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [11:0] p1x = '0, p1y = '0, p2x = '0, p2y = '0, p3x = '0, p3y = '0;
    logic        out_ready = 1'b1;
    logic        busy, out_valid, done;
    logic [11:0] out_x, out_y;
    logic [24:0] num_pontos;

    int checks = 0;
    int errors = 0;
    int qx[$], qy[$];
    int gx[$], gy[$];
    int exp_n = 0;
    int ntransf = 0;
    int stall_cnt = 0;
    int hold_cnt = 0;
    int ready_mode = 0;
    bit done_seen = 1'b0;

    rasterizador_triangulo dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .Ponto1X(p1x), .Ponto1Y(p1y), .Ponto2X(p2x), .Ponto2Y(p2y),
        .Ponto3X(p3x), .Ponto3Y(p3y),
        .out_ready(out_ready), .busy(busy), .out_valid(out_valid),
        .out_x(out_x), .out_y(out_y), .done(done), .num_pontos(num_pontos)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input longint got, input longint req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s got %0d required %0d", nm, got, req);
        end
    endtask

    function automatic int ed(input int ax, ay, bx, by, px, py);
        return (px - bx) * (ay - by) - (ax - bx) * (py - by);
    endfunction

    task automatic build_model(input int x1, y1, x2, y2, x3, y3);
        int xmn, xmx, ymn, ymx, e1, e2, e3;
        bit ok;
        qx.delete(); qy.delete();
        xmn = x1; if (x2 < xmn) xmn = x2; if (x3 < xmn) xmn = x3;
        xmx = x1; if (x2 > xmx) xmx = x2; if (x3 > xmx) xmx = x3;
        ymn = y1; if (y2 < ymn) ymn = y2; if (y3 < ymn) ymn = y3;
        ymx = y1; if (y2 > ymx) ymx = y2; if (y3 > ymx) ymx = y3;
        for (int y = ymn; y <= ymx; y++)
            for (int x = xmn; x <= xmx; x++) begin
                e1 = ed(x1, y1, x2, y2, x, y);
                e2 = ed(x2, y2, x3, y3, x, y);
                e3 = ed(x3, y3, x1, y1, x, y);
                ok = (e1 >= 0) && (e2 >= 0) && (e3 >= 0);
`ifdef ORIENTACAO_DUPLA_EN
                ok = ok || ((e1 <= 0) && (e2 <= 0) && (e3 <= 0));
`endif
                if (ok) begin qx.push_back(x); qy.push_back(y); end
            end
        exp_n = qx.size();
    endtask

    function automatic bit in_model(input int x, input int y);
        foreach (qx[i]) if (qx[i] == x && qy[i] == y) return 1'b1;
        return 1'b0;
    endfunction

    // Checker: every valid cycle must show the next expected point; a transfer pops it.
    always @(negedge clk) begin
        if (rst_n) begin
            if (out_valid) begin
                if (qx.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL extra_point got (%0d,%0d) required none", out_x, out_y);
                end else begin
                    chk("point_x", out_x, qx[0]);
                    chk("point_y", out_y, qy[0]);
                end
                if (out_ready) begin
                    if (qx.size() > 0) begin void'(qx.pop_front()); void'(qy.pop_front()); end
                    gx.push_back(int'(out_x)); gy.push_back(int'(out_y));
                    ntransf++;
                end else begin
                    stall_cnt++;
                end
            end
            if (done) begin
                chk("missing_points", qx.size(), 0);
                chk("num_pontos", num_pontos, exp_n);
                chk("busy_at_done", busy, 0);
                chk("valid_at_done", out_valid, 0);
                done_seen = 1'b1;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0: out_ready = 1'b1;
            1: out_ready = ($urandom_range(0, 3) != 0);
            default: begin
                if (out_valid && hold_cnt < 3) begin
                    out_ready = 1'b0;
                    hold_cnt++;
                end else begin
                    out_ready = 1'b1;
                end
            end
        endcase
    end

    task automatic start_scan(input int x1, y1, x2, y2, x3, y3, input int mode);
        build_model(x1, y1, x2, y2, x3, y3);
        gx.delete(); gy.delete();
        ready_mode = mode; hold_cnt = 0; stall_cnt = 0; ntransf = 0; done_seen = 1'b0;
        @(posedge clk); #2;
        p1x = 12'(x1); p1y = 12'(y1); p2x = 12'(x2); p2y = 12'(y2); p3x = 12'(x3); p3y = 12'(y3);
        start = 1'b1;
        @(posedge clk); #2;
        start = 1'b0;
        chk("busy_after_start", busy, 1);
        // vertices must have been latched on the start edge
        p1x = 12'($urandom); p1y = 12'($urandom); p2x = 12'($urandom);
        p2y = 12'($urandom); p3x = 12'($urandom); p3y = 12'($urandom);
    endtask

    task automatic wait_done();
        int cyc = 0;
        while (!done_seen && cyc < 2000) begin @(posedge clk); cyc++; end
        if (!done_seen) begin
            checks++; errors++;
            $display("FAIL timeout_done got no_done required done");
        end
        @(posedge clk); #2;
        chk("done_one_cycle", done, 0);
        chk("busy_idle", busy, 0);
    endtask

    task automatic run_scan(input int x1, y1, x2, y2, x3, y3, input int mode);
        start_scan(x1, y1, x2, y2, x3, y3, mode);
        wait_done();
    endtask

    initial begin
        int bx, by;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_busy", busy, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_done", done, 0);
        chk("rst_x", out_x, 0);
        chk("rst_y", out_y, 0);
        chk("rst_num", num_pontos, 0);
        @(negedge clk); rst_n = 1'b1;

        // right isoceles, counter-clockwise
        build_model(0, 0, 2, 0, 0, 2);
        chk("model_032_n", qx.size(), 6);
        chk("model_032_p3", qx[3] * 100 + qy[3], 1);
        run_scan(0, 0, 2, 0, 0, 2, 0);
        chk("got_032_n", gx.size(), 6);
        if (gx.size() == 6) begin
            chk("got_032_p0", gx[0] * 100 + gy[0], 0);
            chk("got_032_p1", gx[1] * 100 + gy[1], 100);
            chk("got_032_p2", gx[2] * 100 + gy[2], 200);
            chk("got_032_p3", gx[3] * 100 + gy[3], 1);
            chk("got_032_p4", gx[4] * 100 + gy[4], 101);
            chk("got_032_p5", gx[5] * 100 + gy[5], 2);
        end

        // clockwise winding
        run_scan(0, 0, 0, 2, 2, 0, 1);
`ifdef ORIENTACAO_DUPLA_EN
        chk("cw_points", gx.size(), 6);
`else
        chk("cw_points", gx.size(), 0);
`endif
        chk("cw_num", num_pontos, gx.size());

        build_model(10, 10, 30, 10, 20, 30);
        chk("m034_15_15", in_model(15, 15), 1);
        chk("m034_9_15", in_model(9, 15), 0);
        chk("m034_30_11", in_model(30, 11), 0);
        chk("m034_10_10", in_model(10, 10), 1);
        chk("m034_30_10", in_model(30, 10), 1);
        run_scan(10, 10, 30, 10, 20, 30, 1);

        run_scan(4095, 4095, 4095, 4095, 4095, 4095, 1);
        chk("corner_n", gx.size(), 1);
        if (gx.size() == 1) chk("corner_pt", gx[0] * 10000 + gy[0], 40954095);
        run_scan(0, 0, 2, 0, 4, 0, 0);
        chk("line_n", gx.size(), 5);

        // back-pressure on the first point
        run_scan(0, 0, 2, 0, 0, 2, 2);
        chk("stall_cycles", stall_cnt, 3);
        chk("stall_n", gx.size(), 6);
        if (gx.size() > 0) chk("stall_first", gx[0] * 100 + gy[0], 0);

        // reset mid-scan, then a clean rescan
        begin
            int cyc = 0;
            start_scan(0, 0, 2, 0, 0, 2, 0);
            while (ntransf < 2 && cyc < 100) begin @(negedge clk); cyc++; end
            chk("mid_two_transfers", ntransf, 2);
            @(posedge clk); #2;
            rst_n = 1'b0;
            #1;
            chk("mid_rst_valid", out_valid, 0);
            chk("mid_rst_busy", busy, 0);
            chk("mid_rst_num", num_pontos, 0);
            qx.delete(); qy.delete();
            @(negedge clk); rst_n = 1'b1;
            repeat (3) @(posedge clk);
            #2;
            chk("no_resume", out_valid, 0);
            run_scan(0, 0, 2, 0, 0, 2, 0);
            chk("rescan_n", gx.size(), 6);
            if (gx.size() > 0) chk("rescan_first", gx[0] * 100 + gy[0], 0);
        end

        for (int t = 0; t < 12; t++) begin
            bx = $urandom_range(0, 4083);
            by = $urandom_range(0, 4083);
            run_scan(bx + $urandom_range(0, 12), by + $urandom_range(0, 12),
                     bx + $urandom_range(0, 12), by + $urandom_range(0, 12),
                     bx + $urandom_range(0, 12), by + $urandom_range(0, 12), 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
